// File: rtl/alu16_seq.sv
// Word-width ALU sequencer that drives a 4-bit slice one nibble per cycle, LSB nibble first; latency WIDTH/4 cycles.
// Backpressure: result/flags held while out_valid && !out_ready; in_ready stays low until the result is taken.
module alu16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout,
  output logic [3:0]       alu_src1,
  output logic [3:0]       alu_src2,
  output logic             alu_A_invert,
  output logic             alu_B_invert,
  output logic             alu_cin,
  output logic             alu_less,
  output logic [1:0]       alu_operation,
  input  logic [3:0]       alu_result,
  input  logic             alu_cout
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt, a_sh, b_sh, res_fin;
  logic [KW-1:0]    k;
  logic             carry_q, last;
  logic             is_arith, is_slt, is_logic, legal;
  logic             msb_r, ov_raw;

  always_comb begin
    is_slt   = (ctrl_q == 4'b0111);
    is_arith = (ctrl_q == 4'b0010) || (ctrl_q == 4'b0110) || is_slt;
    is_logic = (ctrl_q == 4'b0000) || (ctrl_q == 4'b0001) || (ctrl_q == 4'b1100);
    legal    = is_arith || is_logic;
    last     = (k == KW'(N - 1));
  end

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Unsupported codes still step through the nibbles, but with the slice held in plain AND mode.
  always_comb begin
    a_sh          = a_q >> {k, 2'b00};
    b_sh          = b_q >> {k, 2'b00};
    alu_src1      = '0;
    alu_src2      = '0;
    alu_A_invert  = 1'b0;
    alu_B_invert  = 1'b0;
    alu_cin       = 1'b0;
    alu_less      = 1'b0;
    alu_operation = 2'b00;
    if (state == RUN) begin
      alu_src1 = a_sh[3:0];
      alu_src2 = b_sh[3:0];
      if (legal) begin
        alu_A_invert  = ctrl_q[3];
        alu_B_invert  = ctrl_q[2];
        alu_operation = is_slt ? 2'b10 : ctrl_q[1:0];
      end
      if (is_arith) alu_cin = (k == '0) ? ctrl_q[2] : carry_q;
    end
  end

  always_comb begin
    acc_nxt = (acc_q & ~(WIDTH'(4'hF) << {k, 2'b00})) | (WIDTH'(alu_result) << {k, 2'b00});
    msb_r   = alu_result[3];
    ov_raw  = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ ctrl_q[2])) && (msb_r != a_q[WIDTH-1]);
    if (!legal)      res_fin = '0;
    else if (is_slt) res_fin = WIDTH'(msb_r ^ ov_raw);
    else             res_fin = acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      k        <= '0;
      carry_q  <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      cout     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          ctrl_q  <= ctrl;
          a_q     <= src1;
          b_q     <= src2;
          acc_q   <= '0;
          k       <= '0;
          carry_q <= 1'b0;
        end
        RUN: begin
          acc_q   <= acc_nxt;
          carry_q <= alu_cout;
          k       <= last ? '0 : k + 1'b1;
          if (last) begin
            result   <= res_fin;
            zero     <= (res_fin == '0);
            overflow <= is_arith && ov_raw;
            cout     <= is_arith && alu_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
